// File: rtl/noc_packet_receiver_if.sv
// rtl/noc_packet_receiver_if.sv - router ejection, payload stream and packet status bundle
`ifndef NOC_RX_DEFS
`define NOC_RX_DEFS
`define Noc_Data_Width   32
`define Noc_ID_X_Width   2
`define Noc_ID_Y_Width   2
`define Noc_Point_H      28
`define Noc_Source_Point 24
`define Axi_TYPE_Bit     2
`define Axi_LEN_Bit      8
`define Axi_Len_Point    8
`define Noc_Point_E      4
`define Noc_Head_H       4'hA
`define Noc_Head_E       4'h5
`define Noc_Tail_H       4'hC
`define Noc_Tail_E       4'h3
`endif

interface noc_packet_receiver_if;
  logic                         receive_valid;
  logic                         receive_ready;
  logic [`Noc_Data_Width-1:0]   receive_flit;
  logic                         receive_is_header;
  logic                         receive_is_tail;
  logic                         out_valid;
  logic                         out_ready;
  logic [`Noc_Data_Width-1:0]   out_data;
  logic                         out_last;
  logic                         pkt_done;
  logic [`Noc_ID_X_Width-1:0]   pkt_src_x;
  logic [`Noc_ID_Y_Width-1:0]   pkt_src_y;
  logic [`Axi_TYPE_Bit-1:0]     pkt_type;
  logic [`Axi_LEN_Bit-1:0]      pkt_len;
  logic [3:0]                   pkt_err;

  modport master (
    output receive_valid, receive_flit, receive_is_header, receive_is_tail, out_ready,
    input  receive_ready, out_valid, out_data, out_last,
    input  pkt_done, pkt_src_x, pkt_src_y, pkt_type, pkt_len, pkt_err
  );

  modport slave (
    input  receive_valid, receive_flit, receive_is_header, receive_is_tail, out_ready,
    output receive_ready, out_valid, out_data, out_last,
    output pkt_done, pkt_src_x, pkt_src_y, pkt_type, pkt_len, pkt_err
  );
endinterface

// File: rtl/noc_packet_receiver.sv
// rtl/noc_packet_receiver.sv - NoC depacketizer: header/tail validation, payload FIFO, status pulse
// Optional feature macro: NOC_RX_DEST_CHECK_EN (drop packets whose dest differs from {X_ID,Y_ID}).
`ifndef NOC_RX_DEFS
`define NOC_RX_DEFS
`define Noc_Data_Width   32
`define Noc_ID_X_Width   2
`define Noc_ID_Y_Width   2
`define Noc_Point_H      28
`define Noc_Source_Point 24
`define Axi_TYPE_Bit     2
`define Axi_LEN_Bit      8
`define Axi_Len_Point    8
`define Noc_Point_E      4
`define Noc_Head_H       4'hA
`define Noc_Head_E       4'h5
`define Noc_Tail_H       4'hC
`define Noc_Tail_E       4'h3
`endif

module noc_packet_receiver #(
  parameter logic [`Noc_ID_X_Width-1:0] X_ID = '0,
  parameter logic [`Noc_ID_Y_Width-1:0] Y_ID = '0,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  noc_clk,
  input logic                  noc_rst,
  noc_packet_receiver_if.slave rx
);
  localparam int DW      = `Noc_Data_Width;
  localparam int XW      = `Noc_ID_X_Width;
  localparam int YW      = `Noc_ID_Y_Width;
  localparam int IDW     = XW + YW;
  localparam int TW      = `Axi_TYPE_Bit;
  localparam int LW      = `Axi_LEN_Bit;
  localparam int CW      = LW + 1;
  localparam int HW      = DW - `Noc_Point_H;
  localparam int EW      = `Axi_Len_Point - `Noc_Point_E;
  localparam int DEST_HI = `Noc_Source_Point - 1;
  localparam int TYPE_HI = DEST_HI - IDW;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int AW1     = AW + 1;

  localparam logic [AW:0]   READY_LIM = AW1'(FIFO_DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE   = AW1'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] LCNT_ONE  = CW'(1);
  localparam logic [CW-1:0] LCNT_MAX  = '1;

  typedef enum logic [1:0] {S_HEAD, S_BODY, S_DROP} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] src_q, src_d;
  logic [TW-1:0]  type_q, type_d;
  logic [LW-1:0]  len_q, len_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     err_q, err_d;
  logic           stg_valid_q, stg_valid_d;
  logic [DW-1:0]  stg_data_q, stg_data_d;
  logic           pkt_done_q, pkt_done_d;
  logic [IDW-1:0] pkt_src_q, pkt_src_d;
  logic [TW-1:0]  pkt_type_q, pkt_type_d;
  logic [LW-1:0]  pkt_len_q, pkt_len_d;
  logic [3:0]     pkt_err_q, pkt_err_d;
  logic           ready_q, ready_d;
  logic [DW:0]    mem_q [FIFO_DEPTH];
  logic [DW:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]    count_q, count_d;

  logic [DW-1:0]  flit;
  logic [HW-1:0]  f_h;
  logic [EW-1:0]  f_e;
  logic [IDW-1:0] f_src;
  logic [IDW-1:0] f_dest;
  logic [TW-1:0]  f_type;
  logic [LW-1:0]  f_len;
  logic           accept, hdr_bad, dest_bad, tail_bad, len_bad;
  logic           push, push_last, pop, out_valid, close, start_hdr;
  logic [3:0]     close_err;

  assign flit   = rx.receive_flit;
  assign f_h    = flit[DW-1:`Noc_Point_H];
  assign f_src  = flit[`Noc_Point_H-1:`Noc_Source_Point];
  assign f_dest = flit[DEST_HI -: IDW];
  assign f_type = flit[TYPE_HI -: TW];
  assign f_len  = flit[`Axi_Len_Point +: LW];
  assign f_e    = flit[`Axi_Len_Point-1:`Noc_Point_E];

  assign accept    = rx.receive_valid && ready_q;
  assign hdr_bad   = (f_h != `Noc_Head_H) || (f_e != `Noc_Head_E);
  assign tail_bad  = (f_h != `Noc_Tail_H) || (f_e != `Noc_Tail_E) || (f_src != src_q);
  assign len_bad   = cnt_q != (CW'(len_q) + LCNT_ONE);
`ifdef NOC_RX_DEST_CHECK_EN
  assign dest_bad  = f_dest != {X_ID, Y_ID};
`else
  // Destination is not checked in this build; every packet is delivered.
  assign dest_bad  = 1'b0 & (f_dest != {X_ID, Y_ID});
`endif

  assign out_valid = count_q != '0;
  assign pop       = out_valid && rx.out_ready;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    type_d      = type_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    stg_valid_d = stg_valid_q;
    stg_data_d  = stg_data_q;
    pkt_done_d  = 1'b0;
    pkt_src_d   = pkt_src_q;
    pkt_type_d  = pkt_type_q;
    pkt_len_d   = pkt_len_q;
    pkt_err_d   = pkt_err_q;
    push        = 1'b0;
    push_last   = 1'b0;
    close       = 1'b0;
    close_err   = 4'b0000;
    start_hdr   = 1'b0;

    if (accept) begin
      unique case (state_q)
        S_HEAD: start_hdr = rx.receive_is_header;
        S_BODY: begin
          // Every flit closes out the staged one; only data flits refill the stage.
          push = stg_valid_q;
          if (rx.receive_is_header) begin
            push_last   = 1'b1;
            close       = 1'b1;
            close_err   = 4'b1000;
            start_hdr   = 1'b1;
            stg_valid_d = 1'b0;
          end else if (rx.receive_is_tail) begin
            push_last   = 1'b1;
            close       = 1'b1;
            close_err   = err_q | {tail_bad, len_bad, 2'b00};
            stg_valid_d = 1'b0;
            state_d     = S_HEAD;
          end else begin
            stg_valid_d = 1'b1;
            stg_data_d  = flit;
            if (cnt_q != LCNT_MAX) cnt_d = cnt_q + LCNT_ONE;
          end
        end
        S_DROP: begin
          if (rx.receive_is_tail && !rx.receive_is_header) begin
            close     = 1'b1;
            close_err = err_q;
            state_d   = S_HEAD;
          end
        end
        default: state_d = S_HEAD;
      endcase
    end

    if (start_hdr) begin
      src_d   = f_src;
      type_d  = f_type;
      len_d   = f_len;
      cnt_d   = '0;
      err_d   = {2'b00, dest_bad, hdr_bad};
      state_d = (hdr_bad || dest_bad) ? S_DROP : S_BODY;
    end

    // Status reports the packet being closed, not a header captured this cycle.
    if (close) begin
      pkt_done_d = 1'b1;
      pkt_src_d  = src_q;
      pkt_type_d = type_q;
      pkt_len_d  = len_q;
      pkt_err_d  = close_err;
    end
  end

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push) begin
      mem_d[wr_q] = {push_last, stg_data_q};
      wr_d        = wr_q + PTR_ONE;
    end
    if (pop) rd_d = rd_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
    // One slot stays free so the staged flit always has room when it is pushed.
    ready_d = count_d < READY_LIM;
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q     <= S_HEAD;
      src_q       <= '0;
      type_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      pkt_done_q  <= 1'b0;
      pkt_src_q   <= '0;
      pkt_type_q  <= '0;
      pkt_len_q   <= '0;
      pkt_err_q   <= '0;
      ready_q     <= 1'b0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      type_q      <= type_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      stg_valid_q <= stg_valid_d;
      stg_data_q  <= stg_data_d;
      pkt_done_q  <= pkt_done_d;
      pkt_src_q   <= pkt_src_d;
      pkt_type_q  <= pkt_type_d;
      pkt_len_q   <= pkt_len_d;
      pkt_err_q   <= pkt_err_d;
      ready_q     <= ready_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge noc_clk) begin
    mem_q <= mem_d;
  end

  assign rx.receive_ready = ready_q;
  assign rx.out_valid     = out_valid;
  assign rx.out_data      = out_valid ? mem_q[rd_q][DW-1:0] : '0;
  assign rx.out_last      = out_valid & mem_q[rd_q][DW];
  assign rx.pkt_done      = pkt_done_q;
  assign rx.pkt_src_x     = pkt_src_q[IDW-1:YW];
  assign rx.pkt_src_y     = pkt_src_q[YW-1:0];
  assign rx.pkt_type      = pkt_type_q;
  assign rx.pkt_len       = pkt_len_q;
  assign rx.pkt_err       = pkt_err_q;
endmodule
